// File: rtl/lap_controller.sv
// Stopwatch run-mode sequencer: start/stop + lap/reset FSM with a circular lap buffer.
// Optional build macro LAP_AUTO_CYCLE_EN adds timed auto-advance while reviewing laps.
module lap_controller #(
    parameter int unsigned DIGITS     = 5,
    parameter int unsigned LAP_DEPTH  = 4,
    parameter int unsigned HOLD_TICKS = 30_000_000,
    parameter int unsigned CYCLE_DIV  = 100_000_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_stop_evt,
    input  logic                             lap_reset_evt,
    input  logic [DIGITS*4-1:0]              live_digits,
    output logic                             clear,
    output logic                             prepare_start,
    output logic                             running,
    output logic [DIGITS*4-1:0]              disp_digits,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
    output logic [$clog2(LAP_DEPTH)-1:0]     lap_index,
    output logic                             review
);

    localparam int unsigned W     = DIGITS * 4;
    localparam int unsigned IdxW  = $clog2(LAP_DEPTH);
    localparam int unsigned CntW  = $clog2(LAP_DEPTH + 1);
    localparam int unsigned HoldW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(LAP_DEPTH - 1);
    localparam logic [CntW-1:0]  MaxCnt   = CntW'(LAP_DEPTH);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_TICKS);

    typedef enum logic [1:0] {StIdle, StRun, StStop, StReview} state_e;

    state_e           state_q, state_d;
    logic             running_q, running_d;
    logic             clear_q, clear_d;
    logic             prep_q, prep_d;
    logic [W-1:0]     disp_q, disp_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [IdxW-1:0]  wr_q, wr_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [W-1:0]     buf_q [LAP_DEPTH];
    logic             capture;
    logic [IdxW-1:0]  newest, oldest;

`ifdef LAP_AUTO_CYCLE_EN
    localparam int unsigned CycW = (CYCLE_DIV > 1) ? $clog2(CYCLE_DIV) : 1;
    localparam logic [CycW-1:0] CycLast = CycW'(CYCLE_DIV - 1);
    logic [CycW-1:0] cyc_q, cyc_d;
`else
    // CYCLE_DIV only matters when auto-cycling is built in.
    logic unused_cycle_div;
    assign unused_cycle_div = ^CYCLE_DIV;
`endif

    function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] i);
        return (i == LastIdx) ? '0 : i + 1'b1;
    endfunction

    assign newest = (wr_q == '0) ? LastIdx : wr_q - 1'b1;
    assign oldest = (count_q == MaxCnt) ? wr_q : '0;

    always_comb begin
        state_d   = state_q;
        running_d = running_q;
        clear_d   = 1'b0;
        prep_d    = 1'b0;
        count_d   = count_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        hold_d    = (state_q == StRun && hold_q != '0) ? hold_q - 1'b1 : hold_q;
        capture   = 1'b0;
`ifdef LAP_AUTO_CYCLE_EN
        cyc_d     = cyc_q;
`endif
        // start_stop is checked first everywhere, so it wins over a simultaneous lap_reset.
        unique case (state_q)
            StIdle: begin
                if (start_stop_evt) begin
                    prep_d    = 1'b1;
                    running_d = 1'b1;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (start_stop_evt) begin
                    running_d = 1'b0;
                    hold_d    = '0;
                    state_d   = StStop;
                end else if (lap_reset_evt) begin
                    capture = 1'b1;
                    wr_d    = inc_idx(wr_q);
                    count_d = (count_q == MaxCnt) ? count_q : count_q + 1'b1;
                    hold_d  = HoldLoad;
                end
            end
            StStop: begin
                if (start_stop_evt) begin
                    prep_d    = 1'b1;
                    running_d = 1'b1;
                    state_d   = StRun;
                end else if (lap_reset_evt) begin
                    if (count_q == '0) begin
                        clear_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d   = oldest;
                        state_d = StReview;
`ifdef LAP_AUTO_CYCLE_EN
                        cyc_d   = '0;
`endif
                    end
                end
            end
            StReview: begin
                if (start_stop_evt) begin
                    state_d = StStop;
                end else if (lap_reset_evt) begin
                    if (idx_q == newest) begin
                        clear_d = 1'b1;
                        count_d = '0;
                        wr_d    = '0;
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d = inc_idx(idx_q);
`ifdef LAP_AUTO_CYCLE_EN
                        cyc_d = '0;
`endif
                    end
                end
`ifdef LAP_AUTO_CYCLE_EN
                else if (cyc_q == CycLast) begin
                    idx_d = (idx_q == newest) ? oldest : inc_idx(idx_q);
                    cyc_d = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        // Display follows the next state so it changes on the same edge as the event.
        if (state_d == StReview) begin
            disp_d = buf_q[idx_d];
        end else if (state_d == StRun && hold_d != '0) begin
            disp_d = capture ? live_digits : buf_q[newest];
        end else begin
            disp_d = live_digits;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
            clear_q   <= 1'b1;
            prep_q    <= 1'b0;
            disp_q    <= live_digits;
            count_q   <= '0;
            idx_q     <= '0;
            wr_q      <= '0;
            hold_q    <= '0;
`ifdef LAP_AUTO_CYCLE_EN
            cyc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            clear_q   <= clear_d;
            prep_q    <= prep_d;
            disp_q    <= disp_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            hold_q    <= hold_d;
`ifdef LAP_AUTO_CYCLE_EN
            cyc_q     <= cyc_d;
`endif
        end
    end

    // Buffer contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (!reset && capture) begin
            buf_q[wr_q] <= live_digits;
        end
    end

    assign clear         = clear_q;
    assign prepare_start = prep_q;
    assign running       = running_q;
    assign disp_digits   = disp_q;
    assign lap_count     = count_q;
    assign lap_index     = idx_q;
    assign review        = (state_q == StReview);

endmodule

// File: tb/tb_lap_controller.sv
// Directed, table-driven bench for lap_controller (HOLD_TICKS=8, CYCLE_DIV=16, LAP_DEPTH=4).
module tb_lap_controller;

    localparam int unsigned DIGITS     = 5;
    localparam int unsigned LAP_DEPTH  = 4;
    localparam int unsigned HOLD_TICKS = 8;
    localparam int unsigned CYCLE_DIV  = 16;
    localparam int unsigned W          = DIGITS * 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         ss;
    logic         lr;
    logic [W-1:0] live;
    logic         clear;
    logic         prep;
    logic         running;
    logic [W-1:0] disp;
    logic [2:0]   lap_count;
    logic [1:0]   lap_index;
    logic         review;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lap_controller #(
        .DIGITS     (DIGITS),
        .LAP_DEPTH  (LAP_DEPTH),
        .HOLD_TICKS (HOLD_TICKS),
        .CYCLE_DIV  (CYCLE_DIV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_stop_evt (ss),
        .lap_reset_evt  (lr),
        .live_digits    (live),
        .clear          (clear),
        .prepare_start  (prep),
        .running        (running),
        .disp_digits    (disp),
        .lap_count      (lap_count),
        .lap_index      (lap_index),
        .review         (review)
    );

    typedef struct {
        logic         ss;
        logic         lr;
        logic [W-1:0] live;
        logic         clr;
        logic         prep;
        logic         run;
        logic [W-1:0] disp;
        int           cnt;
        logic         rev;
        int           idx;   // -1: not checked
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic l, input logic [W-1:0] lv,
                                input logic c, input logic p, input logic r,
                                input logic [W-1:0] d, input int n, input logic rv,
                                input int ix);
        vec_t v;
        v.ss = s; v.lr = l; v.live = lv; v.clr = c; v.prep = p; v.run = r;
        v.disp = d; v.cnt = n; v.rev = rv; v.idx = ix;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic s, input logic l, input logic [W-1:0] v);
        ss = s; lr = l; live = v;
        tick();
        ss = 1'b0; lr = 1'b0;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".clear"}, 32'(clear), 32'(v.clr));
        chk({tag, ".prepare_start"}, 32'(prep), 32'(v.prep));
        chk({tag, ".running"}, 32'(running), 32'(v.run));
        chk({tag, ".disp"}, 32'(disp), 32'(v.disp));
        chk({tag, ".lap_count"}, 32'(lap_count), 32'(v.cnt));
        chk({tag, ".review"}, 32'(review), 32'(v.rev));
        if (v.idx >= 0) chk({tag, ".lap_index"}, 32'(lap_index), 32'(v.idx));
    endtask

    initial begin
        //          ss lr live       clr prep run disp      cnt rev idx
        vecs.push_back(mk(0, 0, 20'h00042, 0, 0, 0, 20'h00042, 0, 0, 0));
        vecs.push_back(mk(0, 0, 20'h00043, 0, 0, 0, 20'h00043, 0, 0, 0));
        vecs.push_back(mk(0, 1, 20'h00044, 0, 0, 0, 20'h00044, 0, 0, 0));  // lap ignored in IDLE
        vecs.push_back(mk(1, 0, 20'h00000, 0, 1, 1, 20'h00000, 0, 0, 0));  // start
        vecs.push_back(mk(0, 0, 20'h00001, 0, 0, 1, 20'h00001, 0, 0, 0));
        vecs.push_back(mk(1, 0, 20'h00002, 0, 0, 0, 20'h00002, 0, 0, 0));  // stop
        vecs.push_back(mk(0, 0, 20'h00002, 0, 0, 0, 20'h00002, 0, 0, 0));
        vecs.push_back(mk(1, 0, 20'h00002, 0, 1, 1, 20'h00002, 0, 0, 0));  // resume
        vecs.push_back(mk(0, 1, 20'h00123, 0, 0, 1, 20'h00123, 1, 0, 0));  // lap
        for (int k = 0; k < 7; k++)
            vecs.push_back(mk(0, 0, 20'h00124 + 20'(k), 0, 0, 1, 20'h00123, 1, 0, 0));
        vecs.push_back(mk(0, 0, 20'h0012b, 0, 0, 1, 20'h0012b, 1, 0, 0));  // hold expired
        vecs.push_back(mk(1, 1, 20'h00200, 0, 0, 0, 20'h00200, 1, 0, 0));  // both: stop wins
        vecs.push_back(mk(0, 0, 20'h00200, 0, 0, 0, 20'h00200, 1, 0, 0));
        vecs.push_back(mk(0, 1, 20'h00200, 0, 0, 0, 20'h00123, 1, 1, 0));  // enter REVIEW
        vecs.push_back(mk(0, 1, 20'h00200, 1, 0, 0, 20'h00200, 0, 0, -1)); // exit from newest
        vecs.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 20'h00000, 0, 0, -1));
        vecs.push_back(mk(0, 1, 20'h00000, 0, 0, 0, 20'h00000, 0, 0, -1));
        vecs.push_back(mk(1, 0, 20'h00000, 0, 1, 1, 20'h00000, 0, 0, -1));
        vecs.push_back(mk(1, 0, 20'h00005, 0, 0, 0, 20'h00005, 0, 0, -1));
        vecs.push_back(mk(0, 1, 20'h00000, 1, 0, 0, 20'h00000, 0, 0, -1)); // STOP, no laps: clear
        vecs.push_back(mk(0, 0, 20'h00000, 0, 0, 0, 20'h00000, 0, 0, -1));
        vecs.push_back(mk(1, 0, 20'h00010, 0, 1, 1, 20'h00010, 0, 0, -1));
        vecs.push_back(mk(0, 1, 20'h00011, 0, 0, 1, 20'h00011, 1, 0, -1));
        vecs.push_back(mk(0, 0, 20'h00012, 0, 0, 1, 20'h00011, 1, 0, -1));
        vecs.push_back(mk(0, 1, 20'h00013, 0, 0, 1, 20'h00013, 2, 0, -1)); // lap during hold
        vecs.push_back(mk(1, 0, 20'h00014, 0, 0, 0, 20'h00014, 2, 0, -1)); // stop cancels hold
        vecs.push_back(mk(1, 0, 20'h00015, 0, 1, 1, 20'h00015, 2, 0, -1));
        vecs.push_back(mk(1, 0, 20'h00016, 0, 0, 0, 20'h00016, 2, 0, -1));
        vecs.push_back(mk(0, 1, 20'h00016, 0, 0, 0, 20'h00011, 2, 1, 0));
        vecs.push_back(mk(1, 0, 20'h00016, 0, 0, 0, 20'h00016, 2, 0, 0));  // REVIEW -> STOP
        vecs.push_back(mk(0, 1, 20'h00016, 0, 0, 0, 20'h00011, 2, 1, 0));
        vecs.push_back(mk(0, 1, 20'h00016, 0, 0, 0, 20'h00013, 2, 1, 1));
        vecs.push_back(mk(0, 1, 20'h00016, 1, 0, 0, 20'h00016, 0, 0, -1));

        reset = 1'b1; ss = 1'b0; lr = 1'b0; live = 20'h00042;
        tick();
        tick();
        reset = 1'b0;
        chk_all("reset", mk(0, 0, 20'h0, 1, 0, 0, 20'h00042, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ss, vecs[i].lr, vecs[i].live);
            chk_all($sformatf("v%0d", i), vecs[i]);
        end

        // Five laps into a four-deep buffer, then review oldest to newest.
        step(1, 0, 20'h0);
        chk("wrap.prep", 32'(prep), 32'd1);
        for (int k = 1; k <= 5; k++) step(0, 1, W'(k));
        chk("wrap.lap_count", 32'(lap_count), 32'd4);
        chk("wrap.disp_last", 32'(disp), 32'd5);
        step(1, 0, 20'h00099);
        chk("wrap.stopped", 32'(running), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 20'h00099);
            chk($sformatf("wrap.r%0d.disp", k), 32'(disp), 32'(k + 2));
            chk($sformatf("wrap.r%0d.idx", k), 32'(lap_index), 32'((k + 1) % 4));
            chk($sformatf("wrap.r%0d.review", k), 32'(review), 32'd1);
        end
        step(0, 1, 20'h00099);
        chk("wrap.exit.clear", 32'(clear), 32'd1);
        chk("wrap.exit.prep", 32'(prep), 32'd0);
        chk("wrap.exit.review", 32'(review), 32'd0);
        chk("wrap.exit.lap_count", 32'(lap_count), 32'd0);
        step(0, 0, 20'h00099);
        chk("wrap.clear_once", 32'(clear), 32'd0);

        // Two laps, then sit in REVIEW with no events.
        step(1, 0, 20'h0);
        step(0, 1, 20'h0000a);
        step(0, 1, 20'h0000b);
        step(1, 0, 20'h00077);
        step(0, 1, 20'h00077);
        chk("auto.enter.idx", 32'(lap_index), 32'd0);
        chk("auto.enter.disp", 32'(disp), 32'h0000a);
`ifdef LAP_AUTO_CYCLE_EN
        for (int p = 0; p < 3; p++) begin
            repeat (CYCLE_DIV - 1) tick();
            chk($sformatf("auto.p%0d.hold", p), 32'(lap_index), 32'(p % 2));
            tick();
            chk($sformatf("auto.p%0d.adv", p), 32'(lap_index), 32'((p + 1) % 2));
            chk($sformatf("auto.p%0d.review", p), 32'(review), 32'd1);
            chk($sformatf("auto.p%0d.disp", p), 32'(disp), ((p % 2) == 0) ? 32'hb : 32'ha);
        end
        step(0, 1, 20'h00077);
        chk("auto.exit.clear", 32'(clear), 32'd1);
        chk("auto.exit.review", 32'(review), 32'd0);
`else
        repeat (40) tick();
        chk("manual.idle.idx", 32'(lap_index), 32'd0);
        chk("manual.idle.review", 32'(review), 32'd1);
        step(0, 1, 20'h00077);
        chk("manual.adv.idx", 32'(lap_index), 32'd1);
        chk("manual.adv.disp", 32'(disp), 32'h0000b);
        step(0, 1, 20'h00077);
        chk("manual.exit.clear", 32'(clear), 32'd1);
        chk("manual.exit.review", 32'(review), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
